// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer: default address
// width and vectors, the sequencer state encoding, fault codes and the
// per-cycle action chosen by the next-PC decode.
// No ports (package).

package pc_sequencer_pkg;

  // Default PC / stack data width and the fixed vectors the PC is loaded with
  localparam int                        SEQ_ADDR_WIDTH   = 12;
  localparam logic [SEQ_ADDR_WIDTH-1:0] SEQ_RESET_VECTOR = 12'h000;
  localparam logic [SEQ_ADDR_WIDTH-1:0] SEQ_INTR_VECTOR  = 12'h004;

  // Sequencer states: normal execution, the single interrupt-entry bubble,
  // and the sticky fault state left only through reset
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_VECTOR = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_t;

  // Fault codes as seen on the fault_code port
  typedef enum logic [1:0] {
    FAULT_NONE      = 2'b00,
    FAULT_OVERFLOW  = 2'b01,
    FAULT_UNDERFLOW = 2'b10
  } fault_code_t;

  // What the sequencer does in the current cycle; decided combinationally
  // so the stack commands and the registered update share one decision
  typedef enum logic [2:0] {
    ACT_HOLD      = 3'd0,
    ACT_IRQ       = 3'd1,
    ACT_RETURN    = 3'd2,
    ACT_CALL      = 3'd3,
    ACT_JUMP      = 3'd4,
    ACT_STEP      = 3'd5,
    ACT_OVERFLOW  = 3'd6,
    ACT_UNDERFLOW = 3'd7
  } seq_action_t;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the program counter and the interrupt-enable flag. Converts decoded
// call/ret/reti/jump and interrupt events into single-cycle push/pop
// commands for the external call/return stack and selects the next PC.
// Stack overflow (call while full) or underflow (ret/reti while empty)
// parks the sequencer in a sticky fault state until reset.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   stall             freeze PC, suppress stack ops and interrupt entry
//   call/ret/reti/jump decoded instruction class (normally one-hot)
//   target            call/jump destination
//   irq               level-sensitive interrupt request
//   ie_set/ie_clr     interrupt-enable control (clear wins)
//   stack_readdata    top of stack (combinational from the stack)
//   stack_empty/full  stack status flags
//   stack_push/pop    combinational stack commands, never both high
//   stack_writedata   value to push (return address)
//   pc                registered program counter
//   flush             registered, high the cycle after a redirect
//   irq_taken         registered one-cycle pulse on interrupt entry
//   int_enabled       interrupt-enable flag
//   fault, fault_code sticky fault flag and cause (01 over, 10 under)

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = SEQ_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = SEQ_RESET_VECTOR,
  parameter logic [ADDR_WIDTH-1:0] INTR_VECTOR  = SEQ_INTR_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  reti,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  irq,
  input  logic                  ie_set,
  input  logic                  ie_clr,
  input  logic [ADDR_WIDTH-1:0] stack_readdata,
  input  logic                  stack_empty,
  input  logic                  stack_full,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [ADDR_WIDTH-1:0] stack_writedata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  flush,
  output logic                  irq_taken,
  output logic                  int_enabled,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  seq_state_t            state;
  seq_action_t           action;
  fault_code_t           fault_code_q;
  logic                  ie;
  logic                  ie_from_ctrl;
  logic [ADDR_WIDTH-1:0] pc_plus_one;

  // Wraps from all-ones back to zero, for both sequential fetch and the
  // return address pushed by a call
  assign pc_plus_one = pc + ADDR_WIDTH'(1);

  // Plain ie_set/ie_clr update; interrupt entry and reti override it below
  assign ie_from_ctrl = ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie);

  // Per-cycle decision in strict priority order. Only RUN does anything;
  // VECTOR and FAULT always hold. An error (empty on return, full on call)
  // becomes a fault action so no stack command is issued on that cycle.
  always_comb begin
    action = ACT_HOLD;
    if (state == ST_RUN && !stall) begin
      if (irq && ie && !stack_full) begin
        action = ACT_IRQ;
      end else if (reti || ret) begin
        action = stack_empty ? ACT_UNDERFLOW : ACT_RETURN;
      end else if (call) begin
        action = stack_full ? ACT_OVERFLOW : ACT_CALL;
      end else if (jump) begin
        action = ACT_JUMP;
      end else begin
        action = ACT_STEP;
      end
    end
  end

  // Stack commands are gated by reset so nothing reaches the stack while
  // the sequencer is being reset; interrupt entry saves the address of the
  // discarded instruction, a call saves the following one
  assign stack_push      = !reset && (action == ACT_IRQ || action == ACT_CALL);
  assign stack_pop       = !reset && (action == ACT_RETURN);
  assign stack_writedata = (action == ACT_IRQ) ? pc : pc_plus_one;

  // FSM and all registered outputs; flush and irq_taken are one-cycle
  // pulses re-derived from the action every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      pc           <= RESET_VECTOR;
      ie           <= 1'b0;
      flush        <= 1'b0;
      irq_taken    <= 1'b0;
      fault        <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      flush     <= 1'b0;
      irq_taken <= 1'b0;
      ie        <= ie_from_ctrl;
      case (state)
        ST_RUN: begin
          case (action)
            ACT_IRQ: begin
              pc        <= INTR_VECTOR;
              ie        <= 1'b0;
              irq_taken <= 1'b1;
              flush     <= 1'b1;
              state     <= ST_VECTOR;
            end
            ACT_RETURN: begin
              pc    <= stack_readdata;
              flush <= 1'b1;
              if (reti) begin
                ie <= 1'b1;
              end
            end
            ACT_CALL, ACT_JUMP: begin
              pc    <= target;
              flush <= 1'b1;
            end
            ACT_STEP: begin
              pc <= pc_plus_one;
            end
            ACT_OVERFLOW: begin
              fault        <= 1'b1;
              fault_code_q <= FAULT_OVERFLOW;
              state        <= ST_FAULT;
            end
            ACT_UNDERFLOW: begin
              fault        <= 1'b1;
              fault_code_q <= FAULT_UNDERFLOW;
              state        <= ST_FAULT;
            end
            default: begin
              pc <= pc;
            end
          endcase
        end
        ST_VECTOR: begin
          state <= ST_RUN;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign int_enabled = ie;
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. The call/return stack is modelled
// as a queue of depth 15 that drives the stack inputs; a behavioural model
// of the sequencer rules predicts every output each cycle. Directed steps
// follow the test plan, then a randomized run exercises the priority rules.

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, call = 1'b0, ret = 1'b0, reti = 1'b0, jump = 1'b0;
  logic        irq = 1'b0, ie_set = 1'b0, ie_clr = 1'b0;
  logic [11:0] target = 12'h000;
  logic [11:0] stack_readdata = 12'h000;
  logic        stack_empty = 1'b1, stack_full = 1'b0;
  logic        stack_push, stack_pop;
  logic [11:0] stack_writedata, pc;
  logic        flush, irq_taken, int_enabled, fault;
  logic [1:0]  fault_code;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: mode 0 = running, 1 = interrupt bubble, 2 = fault
  logic [11:0] m_pc = 12'h000;
  int          m_mode = 0;
  bit          m_ie = 0, m_flush = 0, m_irq_taken = 0;
  logic [1:0]  m_code = 2'b00;
  logic [11:0] stk[$];
  bit          full_ovr = 0, empty_ovr = 0;

  // Combinational outputs captured during the last step
  logic        last_push, last_pop;
  logic [11:0] last_wd;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .call(call), .ret(ret), .reti(reti),
    .jump(jump), .target(target), .irq(irq), .ie_set(ie_set), .ie_clr(ie_clr),
    .stack_readdata(stack_readdata), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_writedata(stack_writedata),
    .pc(pc), .flush(flush), .irq_taken(irq_taken), .int_enabled(int_enabled),
    .fault(fault), .fault_code(fault_code)
  );

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRegs();
    checkOutput("pc", pc, m_pc);
    checkOutput("flush", flush, m_flush);
    checkOutput("irq_taken", irq_taken, m_irq_taken);
    checkOutput("int_enabled", int_enabled, m_ie);
    checkOutput("fault", fault, (m_mode == 2));
    checkOutput("fault_code", fault_code, m_code);
  endtask

  // Asynchronous reset asserted between clock edges; registered outputs
  // must clear without waiting for a clock
  task automatic doReset();
    call = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_pc = 12'h000; m_mode = 0; m_ie = 0; m_flush = 0; m_irq_taken = 0; m_code = 2'b00;
    stk.delete();
    checkRegs();
    checkOutput("push_in_reset", stack_push, 1'b0);
    checkOutput("pop_in_reset", stack_pop, 1'b0);
    stall = 0; call = 0; ret = 0; reti = 0; jump = 0; irq = 0; ie_set = 0; ie_clr = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict and compare, clock, update model
  task automatic applyStimulus(input bit s, input bit c, input bit r, input bit ri, input bit j,
                               input logic [11:0] t, input bit i, input bit is, input bit ic);
    int          act;
    logic [11:0] rd;
    bit          e_full, e_empty, e_push;
    stall = s; call = c; ret = r; reti = ri; jump = j; target = t;
    irq = i; ie_set = is; ie_clr = ic;
    e_empty = (stk.size() == 0) || empty_ovr;
    e_full  = (stk.size() >= 15) || full_ovr;
    rd = (stk.size() != 0) ? stk[stk.size()-1] : 12'h000;
    stack_empty = e_empty; stack_full = e_full; stack_readdata = rd;
    #1;
    // act: 0 hold, 1 irq entry, 2 return, 3 call, 4 jump, 5 step, 6 overflow, 7 underflow
    act = 0;
    if (m_mode == 0 && !s) begin
      if (i && m_ie && !e_full) act = 1;
      else if (r || ri)         act = e_empty ? 7 : 2;
      else if (c)               act = e_full ? 6 : 3;
      else if (j)               act = 4;
      else                      act = 5;
    end
    e_push = (act == 1) || (act == 3);
    last_push = stack_push; last_pop = stack_pop; last_wd = stack_writedata;
    checkRegs();
    checkOutput("stack_push", stack_push, e_push);
    checkOutput("stack_pop", stack_pop, (act == 2));
    if (e_push) checkOutput("stack_writedata", stack_writedata, (act == 1) ? m_pc : m_pc + 12'h001);
    @(posedge clk);
    m_ie = ic ? 1'b0 : (is ? 1'b1 : m_ie);
    m_flush = (act >= 1 && act <= 4);
    m_irq_taken = (act == 1);
    if (m_mode == 1) m_mode = 0;
    case (act)
      1: begin stk.push_back(m_pc); m_pc = 12'h004; m_ie = 0; m_mode = 1; end
      2: begin void'(stk.pop_back()); m_pc = rd; if (ri) m_ie = 1; end
      3: begin stk.push_back(m_pc + 12'h001); m_pc = t; end
      4: m_pc = t;
      5: m_pc = m_pc + 12'h001;
      6: begin m_mode = 2; m_code = 2'b01; end
      7: begin m_mode = 2; m_code = 2'b10; end
      default: ;
    endcase
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 12'h000, 0, 0, 0);
  endtask

  // Free-run until the model PC reaches a value; bounded so it cannot hang
  task automatic runToPc(input logic [11:0] want);
    int n = 0;
    while (m_pc != want && n < 64) begin
      idle();
      n++;
    end
    checkOutput("run_to_pc", pc, want);
  endtask

  initial begin
    $display("[TB] start");
    // Reset and free-run
    @(posedge clk); #1;
    doReset();
    for (int k = 0; k < 4; k++) begin
      checkOutput("freerun_pc", pc, 12'(k));
      idle();
    end

    // Call then return
    runToPc(12'h010);
    applyStimulus(0, 1, 0, 0, 0, 12'h100, 0, 0, 0);
    checkOutput("call_wd", last_wd, 12'h011);
    checkOutput("call_pc", pc, 12'h100);
    checkOutput("call_flush", flush, 1'b1);
    applyStimulus(0, 0, 1, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("ret_pop", last_pop, 1'b1);
    checkOutput("ret_pc", pc, 12'h011);

    // Interrupt entry, bubble, reti
    applyStimulus(0, 0, 0, 0, 0, 12'h000, 0, 1, 0);
    runToPc(12'h020);
    applyStimulus(0, 0, 0, 0, 1, 12'h300, 1, 0, 0);
    checkOutput("irq_wd", last_wd, 12'h020);
    checkOutput("irq_pc", pc, 12'h004);
    checkOutput("irq_taken_pulse", irq_taken, 1'b1);
    checkOutput("irq_ie_clear", int_enabled, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 12'h000, 1, 1, 0);
    checkOutput("vector_pc", pc, 12'h004);
    checkOutput("vector_taken_clear", irq_taken, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 12'h000, 0, 0, 1);
    checkOutput("reti_pc", pc, 12'h020);
    checkOutput("reti_ie", int_enabled, 1'b1);

    // Overflow fault, then deferred interrupt with a full stack
    applyStimulus(0, 0, 0, 0, 1, 12'h030, 0, 0, 0);
    full_ovr = 1;
    applyStimulus(0, 1, 0, 0, 0, 12'h200, 0, 0, 0);
    checkOutput("ovf_no_push", last_push, 1'b0);
    checkOutput("ovf_code", fault_code, 2'b01);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 12'h222, 0, 0, 0);
      checkOutput("fault_pc_hold", pc, 12'h030);
    end
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 12'h000, 0, 1, 0);
    for (int k = 2; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 12'h000, 1, 0, 0);
      checkOutput("irq_deferred_pc", pc, 12'(k));
    end
    full_ovr = 0;

    // Underflow fault and asynchronous reset out of it
    applyStimulus(0, 0, 0, 0, 1, 12'h040, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("unf_no_pop", last_pop, 1'b0);
    checkOutput("unf_code", fault_code, 2'b10);
    checkOutput("unf_pc", pc, 12'h040);
    idle();
    doReset();
    checkOutput("reset_from_fault", fault, 1'b0);

    // Wrap-around
    applyStimulus(0, 0, 0, 0, 1, 12'hFFF, 0, 0, 0);
    idle();
    checkOutput("wrap_pc", pc, 12'h000);
    applyStimulus(0, 0, 0, 0, 1, 12'hFFF, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 12'h123, 0, 0, 0);
    checkOutput("wrap_wd", last_wd, 12'h000);
    applyStimulus(1, 1, 0, 0, 0, 12'h456, 0, 0, 0);
    checkOutput("stall_no_push", last_push, 1'b0);
    checkOutput("stall_pc", pc, 12'h123);

    // Randomized run against the model
    for (int n = 0; n < 800; n++) begin
      int  k;
      bit  c, r, ri, j;
      logic [3:0] mix;
      k = $urandom_range(0, 15);
      c = 0; r = 0; ri = 0; j = 0;
      if (k >= 4 && k <= 6) c = 1;
      else if (k == 7) r = 1;
      else if (k == 8) ri = 1;
      else if (k == 9) j = 1;
      else if (k == 10) begin
        mix = 4'($urandom);
        {c, r, ri, j} = mix;
      end
      full_ovr = ($urandom_range(0, 19) == 0);
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, c, r, ri, j, 12'($urandom),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer that sits directly upstream of the 15-entry, 12-bit call/return stack.
- Owns the PC and the interrupt-enable flag.
- Turns decoded call/ret/reti/jump/interrupt events into single-cycle stack push/pop commands and next-PC selection.
- Detects stack overflow/underflow and parks the core in a fault state.

Parameters:
ADDR_WIDTH, 12, PC and stack data width
RESET_VECTOR, 12'h000, PC value after reset
INTR_VECTOR, 12'h004, PC loaded on interrupt entry

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  freeze PC; no stack ops; no interrupt entry
call  in  1  current instruction is CALL to target
ret  in  1  current instruction is RET
reti  in  1  current instruction is RETI
jump  in  1  current instruction is GOTO to target
target  in  12  call/jump destination
irq  in  1  level-sensitive interrupt request
ie_set  in  1  enable interrupts
ie_clr  in  1  disable interrupts
stack_readdata  in  12  top-of-stack from stack (combinational)
stack_empty  in  1  stack empty flag
stack_full  in  1  stack full flag
stack_push  out  1  push command (combinational)
stack_pop  out  1  pop command (combinational)
stack_writedata  out  12  value to push
pc  out  12  current program counter (registered)
flush  out  1  registered; high one cycle after any redirect
irq_taken  out  1  registered one-cycle pulse on interrupt entry
int_enabled  out  1  interrupt-enable flag
fault  out  1  sticky fault indicator
fault_code  out  2  01 overflow, 10 underflow, 00 none

Behaviour:
- Reset (async, any state): pc=RESET_VECTOR, state=RUN, ie=0, flush=0, irq_taken=0, fault=0, fault_code=00. stack_push/pop are 0 while reset is high.
- States: RUN, VECTOR, FAULT.
- RUN evaluation order, first match wins:
  - stall: pc holds, no push/pop, ie still updates from ie_set/ie_clr.
  - irq && ie && !stack_full: push current pc (instruction not executed); pc<=INTR_VECTOR; ie<=0; irq_taken<=1; flush<=1; go to VECTOR. The decoded instruction in this cycle is discarded.
  - reti: if stack_empty, enter FAULT with code 10. Otherwise pop, pc<=stack_readdata, ie<=1, flush<=1.
  - ret: same as reti without the ie change.
  - call: if stack_full, enter FAULT with code 01. Otherwise push pc+1, pc<=target, flush<=1.
  - jump: pc<=target, flush<=1.
  - none of the above: pc<=pc+1.
- Decoder guarantees call/ret/reti/jump are one-hot; the priority order above still applies if it does not.
- VECTOR: one cycle; pc holds INTR_VECTOR, no stack ops, flush deasserts; return to RUN. irq is not re-sampled in VECTOR.
- FAULT: entered on the same edge the error is detected. No stack op is issued on the faulting cycle. pc frozen at the faulting instruction's address. fault=1, fault_code held. Exit only via reset.
- irq with stack_full: interrupt deferred, not a fault; it stays pending while the level is held.
- push and pop are never asserted together.
- pc+1 wraps 12'hFFF to 12'h000. The pushed pc+1 also wraps.
- ie update: ie_clr beats ie_set. Irq entry clears ie and reti sets ie, both overriding ie_set/ie_clr in the same cycle.
- flush and irq_taken are cleared every cycle they are not re-asserted.

Decomposition:
- Shared package: state encoding (RUN/VECTOR/FAULT), fault codes, RESET_VECTOR/INTR_VECTOR constants, ADDR_WIDTH.
- No sub-module; the next-PC mux and FSM stay in one file. The existing stack module is instantiated alongside it at the core level, not inside.

Test Plan:
- Reset then 3 free-running cycles -> pc 000,001,002,003; no push/pop; flush=0.
- pc=010, call target=100 -> stack_push=1, stack_writedata=011, next pc=100, flush=1 next cycle; then ret with stack_readdata=011 -> stack_pop=1, pc=011.
- ie_set, then irq at pc=020 -> push 020, pc=004, irq_taken pulse, int_enabled=0, one VECTOR cycle; reti -> pop, pc=020, int_enabled=1.
- stack_full=1 and call at pc=030 -> no push, fault=1, fault_code=01, pc stays 030 for 5 cycles; irq with stack_full and ie=1 -> no entry, pc increments.
- ret with stack_empty=1 at pc=040 -> fault_code=10, no pop; assert reset mid-FAULT asynchronously -> pc=000 immediately, fault=0.
- pc=FFF free-run -> pc=000; call at FFF -> writedata=000; stall during call -> no push, pc held.
